// File: rtl/conn_setup_pkg.sv
// Shared types and helpers for the connection-setup agent: setconn types,
// request classes, FSM states and the UDP header layout.
package conn_setup_pkg;

   localparam int unsigned HDR_W  = 112;
   localparam int unsigned PORT_W = 16;
   localparam int unsigned CNT_W  = 7;
   localparam int unsigned REJ_W  = 16;

   typedef enum logic [5:0] {SC_OPEN = 6'd1, SC_CLOSE = 6'd2} setconn_type_e;
   typedef enum logic [1:0] {REQ_OPEN, REQ_CLOSE, REQ_DROP} req_class_e;
   typedef enum logic [2:0] {ST_IDLE, ST_DRAIN, ST_CMD, ST_RHDR, ST_RPLD} state_e;

   typedef struct packed {
      logic [15:0] length;
      logic [15:0] dest_port;
      logic [15:0] src_port;
      logic [31:0] dest_ip;
      logic [31:0] src_ip;
   } udp_hdr_t;

   localparam logic [63:0] NACK_PAYLOAD = 64'hFFFF_FFFF_FFFF_FFFF;

   // Opens target port 0 from a live port; closes come from port 0 naming the slot.
   function automatic req_class_e classify(input logic [15:0] dest_port,
                                           input logic [15:0] src_port);
      if (dest_port == 16'd0 && src_port != 16'd0)      return REQ_OPEN;
      else if (src_port == 16'd0 && dest_port != 16'd0) return REQ_CLOSE;
      else                                              return REQ_DROP;
   endfunction

   function automatic udp_hdr_t reply_hdr(input logic [31:0] req_src_ip,
                                          input logic [31:0] req_dest_ip,
                                          input logic [15:0] req_src_port,
                                          input logic [15:0] slot,
                                          input logic [15:0] len);
      udp_hdr_t h;
      h.length    = len;
      h.dest_port = req_src_port;
      h.src_port  = slot;
      h.dest_ip   = req_src_ip;
      h.src_ip    = req_dest_ip;
      return h;
   endfunction

endpackage

// File: rtl/conn_setup_agent_slot_pool.sv
// Free-slot bitmap with a lowest-free priority encoder, alloc/free ports,
// full flag and allocated-slot counter.
module conn_setup_agent_slot_pool
   import conn_setup_pkg::*;
#(
   parameter  int unsigned NUM_SLOTS = 16,
   localparam int unsigned IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_alloc,
   input  logic             i_free,
   input  logic [IDX_W-1:0] i_free_idx,
   output logic [IDX_W-1:0] o_low_idx_c,
   output logic             o_full_c,
   output logic             o_idx_free_c,
   output logic [CNT_W-1:0] o_active_count
);

   logic [NUM_SLOTS-1:0] r_free;
   logic [CNT_W-1:0]     r_active;
   logic [IDX_W-1:0]     w_low_idx;

   // Scan high to low so the lowest free index wins.
   always_comb begin
      w_low_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (r_free[i]) w_low_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_free   <= '1;
         r_active <= '0;
      end else if (i_alloc) begin
         r_free[w_low_idx] <= 1'b0;
         r_active          <= r_active + CNT_W'(1);
      end else if (i_free) begin
         r_free[i_free_idx] <= 1'b1;
         r_active           <= r_active - CNT_W'(1);
      end
   end

   assign o_low_idx_c    = w_low_idx;
   assign o_full_c       = ~|r_free;
   assign o_idx_free_c   = r_free[i_free_idx];
   assign o_active_count = r_active;

endmodule

// File: rtl/conn_setup_agent.sv
// Slave-side connection manager: drains open/close requests, allocates or frees
// pool slots, issues setconn commands and replies to openers with their slot.
module conn_setup_agent
   import conn_setup_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 16,
   parameter int unsigned SLOT_BASE = 1,
   parameter int unsigned SLOT_W    = 10,
   parameter int unsigned TYPE_W    = 6,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned REPLY_LEN = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [HDR_W-1:0]         usr_rx_hdr_tdata,
   input  logic                     usr_rx_hdr_tvalid,
   output logic                     usr_rx_hdr_tready,
   input  logic [DATA_W-1:0]        usr_rx_payload_tdata,
   input  logic [DATA_W/8-1:0]      usr_rx_payload_tkeep,
   input  logic                     usr_rx_payload_tlast,
   input  logic                     usr_rx_payload_tuser,
   input  logic                     usr_rx_payload_tvalid,
   output logic                     usr_rx_payload_tready,
   output logic [SLOT_W+TYPE_W-1:0] conn_setup_req_tdata,
   output logic                     conn_setup_req_tvalid,
   input  logic                     conn_setup_req_tready,
   output logic [HDR_W-1:0]         usr_tx_hdr_tdata,
   output logic                     usr_tx_hdr_tvalid,
   input  logic                     usr_tx_hdr_tready,
   output logic [DATA_W-1:0]        usr_tx_payload_tdata,
   output logic [DATA_W/8-1:0]      usr_tx_payload_tkeep,
   output logic                     usr_tx_payload_tlast,
   output logic                     usr_tx_payload_tuser,
   output logic                     usr_tx_payload_tvalid,
   input  logic                     usr_tx_payload_tready,
   output logic [CNT_W-1:0]         active_count,
   output logic [REJ_W-1:0]         reject_count
);

   localparam int unsigned IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned KEEP_W = DATA_W / 8;
   localparam int unsigned CMD_W  = SLOT_W + TYPE_W;
   localparam logic [PORT_W-1:0] SLOT_LO = PORT_W'(SLOT_BASE);
   localparam logic [PORT_W-1:0] SLOT_HI = PORT_W'(SLOT_BASE + NUM_SLOTS - 1);
   localparam logic [PORT_W-1:0] RLEN    = PORT_W'(REPLY_LEN);

   state_e             r_state;
   req_class_e         r_class;
   udp_hdr_t           r_hdr;
   logic [PORT_W-1:0]  r_slot;
   logic               r_nack;
   logic               r_cmd_open;
   logic               r_hdr_tready;
   logic               r_pld_tready;
   logic [CMD_W-1:0]   r_req_tdata;
   logic               r_req_tvalid;
   udp_hdr_t           r_tx_hdr;
   logic               r_tx_hdr_tvalid;
   logic [DATA_W-1:0]  r_tx_pld_tdata;
   logic [KEEP_W-1:0]  r_tx_pld_tkeep;
   logic               r_tx_pld_tlast;
   logic               r_tx_pld_tvalid;
   logic [REJ_W-1:0]   r_reject;

   udp_hdr_t           w_rx_hdr;
   logic               w_hdr_hs;
   logic               w_pld_last;
   logic               w_full;
   logic               w_idx_free;
   logic               w_close_ok;
   logic               w_alloc;
   logic               w_free;
   logic [IDX_W-1:0]   w_low_idx;
   logic [IDX_W-1:0]   w_close_idx;
   logic [PORT_W-1:0]  w_close_off;
   logic [PORT_W-1:0]  w_alloc_slot;
   logic               w_unused;

   assign w_rx_hdr     = udp_hdr_t'(usr_rx_hdr_tdata);
   assign w_hdr_hs     = usr_rx_hdr_tvalid & r_hdr_tready;
   assign w_pld_last   = usr_rx_payload_tvalid & r_pld_tready & usr_rx_payload_tlast;
   assign w_close_off  = r_hdr.dest_port - SLOT_LO;
   assign w_close_idx  = IDX_W'(w_close_off);
   assign w_close_ok   = (r_hdr.dest_port >= SLOT_LO) && (r_hdr.dest_port <= SLOT_HI) && !w_idx_free;
   assign w_alloc      = (r_state == ST_DRAIN) && w_pld_last && (r_class == REQ_OPEN) && !w_full;
   assign w_free       = (r_state == ST_DRAIN) && w_pld_last && (r_class == REQ_CLOSE) && w_close_ok;
   assign w_alloc_slot = SLOT_LO + PORT_W'(w_low_idx);

   conn_setup_agent_slot_pool #(.NUM_SLOTS(NUM_SLOTS)) u_pool (
      .clk            (aclk),
      .rst_n          (aresetn),
      .i_alloc        (w_alloc),
      .i_free         (w_free),
      .i_free_idx     (w_close_idx),
      .o_low_idx_c    (w_low_idx),
      .o_full_c       (w_full),
      .o_idx_free_c   (w_idx_free),
      .o_active_count (active_count)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state         <= ST_IDLE;
         r_class         <= REQ_DROP;
         r_hdr           <= '0;
         r_slot          <= '0;
         r_nack          <= 1'b0;
         r_cmd_open      <= 1'b0;
         r_hdr_tready    <= 1'b0;
         r_pld_tready    <= 1'b0;
         r_req_tdata     <= '0;
         r_req_tvalid    <= 1'b0;
         r_tx_hdr        <= '0;
         r_tx_hdr_tvalid <= 1'b0;
         r_tx_pld_tdata  <= '0;
         r_tx_pld_tkeep  <= '0;
         r_tx_pld_tlast  <= 1'b0;
         r_tx_pld_tvalid <= 1'b0;
         r_reject        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hdr_hs) begin
                  r_hdr        <= w_rx_hdr;
                  r_class      <= classify(w_rx_hdr.dest_port, w_rx_hdr.src_port);
                  r_hdr_tready <= 1'b0;
                  r_pld_tready <= 1'b1;
                  r_state      <= ST_DRAIN;
               end else begin
                  r_hdr_tready <= 1'b1;
               end
            end
            // Pool and counters change only on the tlast beat.
            ST_DRAIN: begin
               if (w_pld_last) begin
                  r_pld_tready <= 1'b0;
                  if (w_alloc) begin
                     r_slot       <= w_alloc_slot;
                     r_nack       <= 1'b0;
                     r_cmd_open   <= 1'b1;
                     r_req_tdata  <= {SLOT_W'(w_alloc_slot), TYPE_W'(SC_OPEN)};
                     r_req_tvalid <= 1'b1;
                     r_state      <= ST_CMD;
                  end else if (w_free) begin
                     r_cmd_open   <= 1'b0;
                     r_req_tdata  <= {SLOT_W'(r_hdr.dest_port), TYPE_W'(SC_CLOSE)};
                     r_req_tvalid <= 1'b1;
                     r_state      <= ST_CMD;
                  end else if (r_class == REQ_OPEN) begin
                     r_slot          <= '0;
                     r_nack          <= 1'b1;
                     r_reject        <= (r_reject == '1) ? r_reject : r_reject + REJ_W'(1);
                     r_tx_hdr        <= reply_hdr(r_hdr.src_ip, r_hdr.dest_ip, r_hdr.src_port, '0, RLEN);
                     r_tx_hdr_tvalid <= 1'b1;
                     r_state         <= ST_RHDR;
                  end else begin
                     r_hdr_tready <= 1'b1;
                     r_state      <= ST_IDLE;
                  end
               end
            end
            ST_CMD: begin
               if (conn_setup_req_tready) begin
                  r_req_tvalid <= 1'b0;
                  if (r_cmd_open) begin
                     r_tx_hdr        <= reply_hdr(r_hdr.src_ip, r_hdr.dest_ip, r_hdr.src_port, r_slot, RLEN);
                     r_tx_hdr_tvalid <= 1'b1;
                     r_state         <= ST_RHDR;
                  end else begin
                     r_hdr_tready <= 1'b1;
                     r_state      <= ST_IDLE;
                  end
               end
            end
            ST_RHDR: begin
               if (usr_tx_hdr_tready) begin
                  r_tx_hdr_tvalid <= 1'b0;
                  r_tx_pld_tdata  <= r_nack ? DATA_W'(NACK_PAYLOAD) : DATA_W'(r_slot);
                  r_tx_pld_tkeep  <= '1;
                  r_tx_pld_tlast  <= 1'b1;
                  r_tx_pld_tvalid <= 1'b1;
                  r_state         <= ST_RPLD;
               end
            end
            ST_RPLD: begin
               if (usr_tx_payload_tready) begin
                  r_tx_pld_tvalid <= 1'b0;
                  r_hdr_tready    <= 1'b1;
                  r_state         <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign usr_rx_hdr_tready     = r_hdr_tready;
   assign usr_rx_payload_tready = r_pld_tready;
   assign conn_setup_req_tdata  = r_req_tdata;
   assign conn_setup_req_tvalid = r_req_tvalid;
   assign usr_tx_hdr_tdata      = r_tx_hdr;
   assign usr_tx_hdr_tvalid     = r_tx_hdr_tvalid;
   assign usr_tx_payload_tdata  = r_tx_pld_tdata;
   assign usr_tx_payload_tkeep  = r_tx_pld_tkeep;
   assign usr_tx_payload_tlast  = r_tx_pld_tlast;
   assign usr_tx_payload_tuser  = 1'b0;
   assign usr_tx_payload_tvalid = r_tx_pld_tvalid;
   assign reject_count          = r_reject;

   // Payload content and the request length are intentionally ignored.
   assign w_unused = ^{usr_rx_payload_tdata, usr_rx_payload_tkeep, usr_rx_payload_tuser,
                       r_hdr.length, w_close_off[PORT_W-1:IDX_W]};

endmodule

// File: tb/tb_conn_setup_agent.sv
// Scoreboard bench for conn_setup_agent: directed open/close/drop requests,
// backpressure and mid-request reset, with expected outputs queued at issue time.
`timescale 1ns/1ps
module tb_conn_setup_agent;

   localparam logic [31:0] IP_SRC = 32'hC0A8_0102;  // 192.168.1.2 (requester)
   localparam logic [31:0] IP_DST = 32'hC0A8_0180;  // 192.168.1.128 (this agent)

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [111:0]  usr_rx_hdr_tdata;
   logic          usr_rx_hdr_tvalid;
   logic          usr_rx_hdr_tready;
   logic [63:0]   usr_rx_payload_tdata;
   logic [7:0]    usr_rx_payload_tkeep;
   logic          usr_rx_payload_tlast;
   logic          usr_rx_payload_tuser;
   logic          usr_rx_payload_tvalid;
   logic          usr_rx_payload_tready;
   logic [15:0]   conn_setup_req_tdata;
   logic          conn_setup_req_tvalid;
   logic          conn_setup_req_tready;
   logic [111:0]  usr_tx_hdr_tdata;
   logic          usr_tx_hdr_tvalid;
   logic          usr_tx_hdr_tready;
   logic [63:0]   usr_tx_payload_tdata;
   logic [7:0]    usr_tx_payload_tkeep;
   logic          usr_tx_payload_tlast;
   logic          usr_tx_payload_tuser;
   logic          usr_tx_payload_tvalid;
   logic          usr_tx_payload_tready;
   logic [6:0]    active_count;
   logic [15:0]   reject_count;

   always #5 aclk = ~aclk;

   conn_setup_agent #(
      .NUM_SLOTS(16), .SLOT_BASE(1), .SLOT_W(10), .TYPE_W(6), .DATA_W(64), .REPLY_LEN(16)
   ) dut (
      .aclk                  (aclk),
      .aresetn               (aresetn),
      .usr_rx_hdr_tdata      (usr_rx_hdr_tdata),
      .usr_rx_hdr_tvalid     (usr_rx_hdr_tvalid),
      .usr_rx_hdr_tready     (usr_rx_hdr_tready),
      .usr_rx_payload_tdata  (usr_rx_payload_tdata),
      .usr_rx_payload_tkeep  (usr_rx_payload_tkeep),
      .usr_rx_payload_tlast  (usr_rx_payload_tlast),
      .usr_rx_payload_tuser  (usr_rx_payload_tuser),
      .usr_rx_payload_tvalid (usr_rx_payload_tvalid),
      .usr_rx_payload_tready (usr_rx_payload_tready),
      .conn_setup_req_tdata  (conn_setup_req_tdata),
      .conn_setup_req_tvalid (conn_setup_req_tvalid),
      .conn_setup_req_tready (conn_setup_req_tready),
      .usr_tx_hdr_tdata      (usr_tx_hdr_tdata),
      .usr_tx_hdr_tvalid     (usr_tx_hdr_tvalid),
      .usr_tx_hdr_tready     (usr_tx_hdr_tready),
      .usr_tx_payload_tdata  (usr_tx_payload_tdata),
      .usr_tx_payload_tkeep  (usr_tx_payload_tkeep),
      .usr_tx_payload_tlast  (usr_tx_payload_tlast),
      .usr_tx_payload_tuser  (usr_tx_payload_tuser),
      .usr_tx_payload_tvalid (usr_tx_payload_tvalid),
      .usr_tx_payload_tready (usr_tx_payload_tready),
      .active_count          (active_count),
      .reject_count          (reject_count)
   );

   int unsigned  n_vec = 0;
   int unsigned  n_err = 0;
   logic [15:0]  q_cmd[$];
   logic [111:0] q_rh[$];
   logic [63:0]  q_rp[$];

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic void tmo(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: handshake did not occur within the cycle budget", name);
   endfunction

   function automatic logic [111:0] mk_hdr(input logic [15:0] len, input logic [15:0] dp,
                                           input logic [15:0] sp, input logic [31:0] dip,
                                           input logic [31:0] sip);
      return {len, dp, sp, dip, sip};
   endfunction

   // Output monitors: each handshake pops the next expected item.
   always @(negedge aclk) begin
      if (aresetn && conn_setup_req_tvalid && conn_setup_req_tready) begin
         if (q_cmd.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL setconn_unexpected: got %0h, expected no command", conn_setup_req_tdata);
         end else chk("setconn", 128'(conn_setup_req_tdata), 128'(q_cmd.pop_front()));
      end
      if (aresetn && usr_tx_hdr_tvalid && usr_tx_hdr_tready) begin
         if (q_rh.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL reply_hdr_unexpected: got %0h, expected no reply", usr_tx_hdr_tdata);
         end else chk("reply_hdr", 128'(usr_tx_hdr_tdata), 128'(q_rh.pop_front()));
      end
      if (aresetn && usr_tx_payload_tvalid && usr_tx_payload_tready) begin
         if (q_rp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL reply_pld_unexpected: got %0h, expected no reply", usr_tx_payload_tdata);
         end else chk("reply_pld",
                      128'({usr_tx_payload_tkeep, usr_tx_payload_tlast, usr_tx_payload_tuser, usr_tx_payload_tdata}),
                      128'({8'hFF, 1'b1, 1'b0, q_rp.pop_front()}));
      end
   end

   task automatic send_hdr(input logic [111:0] h);
      int t = 0;
      @(posedge aclk); #1;
      usr_rx_hdr_tdata  = h;
      usr_rx_hdr_tvalid = 1'b1;
      @(negedge aclk);
      while (!usr_rx_hdr_tready && t < 100) begin @(negedge aclk); t++; end
      if (t >= 100) tmo("rx_hdr");
      @(posedge aclk); #1;
      usr_rx_hdr_tvalid = 1'b0;
   endtask

   task automatic send_beats(input int beats);
      for (int b = 0; b < beats; b++) begin
         int t = 0;
         usr_rx_payload_tdata  = {32'hABCD_0000, 32'(b)};
         usr_rx_payload_tlast  = (b == beats - 1);
         usr_rx_payload_tvalid = 1'b1;
         @(negedge aclk);
         while (!usr_rx_payload_tready && t < 100) begin @(negedge aclk); t++; end
         if (t >= 100) tmo("rx_payload");
         @(posedge aclk); #1;
         usr_rx_payload_tvalid = 1'b0;
         usr_rx_payload_tlast  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge aclk);
      while (!(usr_rx_hdr_tready && q_cmd.size() == 0 && q_rh.size() == 0 && q_rp.size() == 0)
             && t < 200) begin
         @(negedge aclk); t++;
      end
      if (t >= 200) tmo("return_to_idle");
   endtask

   task automatic send_req(input logic [15:0] sp, input logic [15:0] dp, input int beats);
      send_hdr(mk_hdr(16'(8 + 8 * beats), dp, sp, IP_DST, IP_SRC));
      send_beats(beats);
   endtask

   // Open from requester port sp; slot 0 means a NACK is expected.
   task automatic do_open(input logic [15:0] sp, input logic [15:0] slot);
      if (slot != 16'd0) q_cmd.push_back({slot[9:0], 6'd1});
      q_rh.push_back(mk_hdr(16'd16, sp, slot, IP_SRC, IP_DST));
      q_rp.push_back((slot == 16'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(slot));
      send_req(sp, 16'd0, 1);
      wait_idle();
   endtask

   task automatic do_close(input logic [15:0] dp, input logic expect_cmd);
      if (expect_cmd) q_cmd.push_back({dp[9:0], 6'd2});
      send_req(16'd0, dp, 1);
      wait_idle();
   endtask

   task automatic wait_valid(input int which, input string name);
      int t = 0;
      @(negedge aclk);
      while (!((which == 0) ? conn_setup_req_tvalid :
               (which == 1) ? usr_tx_hdr_tvalid : usr_tx_payload_tvalid) && t < 50) begin
         @(negedge aclk); t++;
      end
      if (t >= 50) tmo(name);
   endtask

   task automatic check_outputs_zero(input string name);
      chk({name, "_ctrl"},
          128'({usr_rx_hdr_tready, usr_rx_payload_tready, conn_setup_req_tvalid, usr_tx_hdr_tvalid,
                usr_tx_payload_tvalid, usr_tx_payload_tkeep, usr_tx_payload_tlast, usr_tx_payload_tuser,
                active_count, reject_count, conn_setup_req_tdata}), 128'd0);
      chk({name, "_tx_hdr"}, 128'(usr_tx_hdr_tdata), 128'd0);
      chk({name, "_tx_pld"}, 128'(usr_tx_payload_tdata), 128'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn               = 1'b0;
      usr_rx_hdr_tdata      = '0;
      usr_rx_hdr_tvalid     = 1'b0;
      usr_rx_payload_tdata  = '0;
      usr_rx_payload_tkeep  = 8'hFF;
      usr_rx_payload_tlast  = 1'b0;
      usr_rx_payload_tuser  = 1'b0;
      usr_rx_payload_tvalid = 1'b0;
      conn_setup_req_tready = 1'b1;
      usr_tx_hdr_tready     = 1'b1;
      usr_tx_payload_tready = 1'b1;

      repeat (3) @(negedge aclk);
      check_outputs_zero("reset");
      aresetn = 1'b1;
      #1 check_outputs_zero("post_reset");

      // First open: slot 1, setconn 0x0041, reply 192.168.1.128:1 -> 192.168.1.2:20.
      q_cmd.push_back(16'h0041);
      q_rh.push_back({16'd16, 16'd20, 16'd1, 32'hC0A8_0102, 32'hC0A8_0180});
      q_rp.push_back(64'h0000_0000_0000_0001);
      send_req(16'd20, 16'd0, 1);
      wait_idle();
      chk("active_after_first", 128'(active_count), 128'd1);

      for (int k = 2; k <= 16; k++) do_open(16'(100 + k), 16'(k));
      chk("active_full", 128'(active_count), 128'd16);
      chk("reject_before_nack", 128'(reject_count), 128'd0);

      do_open(16'd300, 16'd0);
      chk("reject_after_nack", 128'(reject_count), 128'd1);
      chk("active_after_nack", 128'(active_count), 128'd16);

      q_cmd.push_back(16'h0282);
      send_req(16'd0, 16'd10, 1);
      wait_idle();
      chk("active_after_close10", 128'(active_count), 128'd15);
      do_open(16'd301, 16'd10);
      chk("active_after_reopen10", 128'(active_count), 128'd16);

      do_close(16'd3, 1'b1);
      do_close(16'd3, 1'b0);
      chk("active_after_double_close", 128'(active_count), 128'd15);
      do_open(16'd302, 16'd3);

      do_close(16'd40, 1'b0);
      do_close(16'd17, 1'b0);
      send_req(16'd20, 16'd10, 3);
      wait_idle();
      chk("active_after_drops", 128'(active_count), 128'd16);
      chk("reject_after_drops", 128'(reject_count), 128'd1);

      // Backpressure: everything held for 5 cycles at each stage.
      do_close(16'd16, 1'b1);
      @(posedge aclk); #1;
      conn_setup_req_tready = 1'b0;
      usr_tx_hdr_tready     = 1'b0;
      usr_tx_payload_tready = 1'b0;
      q_cmd.push_back(16'h0401);
      q_rh.push_back(mk_hdr(16'd16, 16'd77, 16'd16, IP_SRC, IP_DST));
      q_rp.push_back(64'd16);
      send_req(16'd77, 16'd0, 1);
      wait_valid(0, "bp_cmd_valid");
      for (int i = 0; i < 5; i++) begin
         chk("bp_cmd_hold", 128'({usr_rx_hdr_tready, conn_setup_req_tvalid, conn_setup_req_tdata}),
             128'({1'b0, 1'b1, 16'h0401}));
         @(negedge aclk);
      end
      @(posedge aclk); #1 conn_setup_req_tready = 1'b1;
      wait_valid(1, "bp_hdr_valid");
      for (int i = 0; i < 5; i++) begin
         chk("bp_hdr_hold", 128'({usr_rx_hdr_tready, usr_tx_hdr_tvalid, usr_tx_hdr_tdata}),
             128'({1'b0, 1'b1, mk_hdr(16'd16, 16'd77, 16'd16, IP_SRC, IP_DST)}));
         @(negedge aclk);
      end
      @(posedge aclk); #1 usr_tx_hdr_tready = 1'b1;
      wait_valid(2, "bp_pld_valid");
      for (int i = 0; i < 5; i++) begin
         chk("bp_pld_hold", 128'({usr_rx_hdr_tready, usr_tx_payload_tvalid, usr_tx_payload_tdata}),
             128'({1'b0, 1'b1, 64'd16}));
         @(negedge aclk);
      end
      @(posedge aclk); #1 usr_tx_payload_tready = 1'b1;
      wait_idle();
      chk("active_after_bp", 128'(active_count), 128'd16);

      // Reset while an open is in DRAIN.
      send_hdr(mk_hdr(16'd16, 16'd0, 16'd55, IP_DST, IP_SRC));
      @(negedge aclk);
      chk("drain_readies", 128'({usr_rx_hdr_tready, usr_rx_payload_tready}), 128'({1'b0, 1'b1}));
      #2 aresetn = 1'b0;
      #1 check_outputs_zero("mid_reset");
      @(negedge aclk);
      aresetn = 1'b1;
      #1 check_outputs_zero("mid_reset_release");
      do_open(16'd56, 16'd1);
      chk("active_after_reset_open", 128'(active_count), 128'd1);
      chk("reject_after_reset", 128'(reject_count), 128'd0);

      repeat (5) @(negedge aclk);
      chk("queues_drained", 128'(q_cmd.size() + q_rh.size() + q_rp.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conn_setup_agent.md
Name: conn_setup_agent

Overview:
Slave-side connection manager that sits on the user RX/TX path of one net-stack core. It generalises the single-slot dummy setup responder into a parametrised slot pool. It consumes open and close requests arriving as UDP header plus payload, allocates or frees slot IDs, issues set-connection commands to the core, and replies to the requester with the allocated slot.

Parameters:
NUM_SLOTS, 16, number of managed slots (1..64)
SLOT_BASE, 1, first slot ID in the pool; the pool covers SLOT_BASE..SLOT_BASE+NUM_SLOTS-1; must be >=1
SLOT_W, 10, slot-ID field width in the setconn word
TYPE_W, 6, type field width in the setconn word; SLOT_W+TYPE_W=16
DATA_W, 64, payload width
REPLY_LEN, 16, UDP length field of the reply (8-byte UDP header plus one beat)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
usr_rx_hdr_tdata  in  112  {length, dest_port, src_port, dest_ip, src_ip}, 16/16/16/32/32 bits, MSB first
usr_rx_hdr_tvalid / usr_rx_hdr_tready  in / out  1  header handshake
usr_rx_payload_tdata / tkeep / tlast / tuser  in  64/8/1/1  request payload
usr_rx_payload_tvalid / usr_rx_payload_tready  in / out  1  payload handshake
conn_setup_req_tdata  out  16  {slot[15:6], type[5:0]}; OPEN=1, CLOSE=2
conn_setup_req_tvalid / conn_setup_req_tready  out / in  1  command handshake
usr_tx_hdr_tdata  out  112  reply header, same field layout as RX
usr_tx_hdr_tvalid / usr_tx_hdr_tready  out / in  1
usr_tx_payload_tdata / tkeep / tlast / tuser  out  64/8/1/1  reply beat
usr_tx_payload_tvalid / usr_tx_payload_tready  out / in  1
active_count  out  7  number of allocated slots
reject_count  out  16  open requests refused because the pool was full; saturates

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE.
  - Free bitmap is all ones.
  - All valids and readies are 0; all counters are 0; all tdata outputs are 0.
- FSM states: IDLE -> DRAIN -> (CMD) -> (RHDR -> RPLD) -> IDLE.
- IDLE:
  - hdr_tready=1 and payload_tready=0.
  - On a header handshake, latch src/dst IP and ports, then go to DRAIN.
  - Classify the request:
    - OPEN when dest_port==0 and src_port!=0.
    - CLOSE when src_port==0 and dest_port!=0.
    - Anything else is DROP.
- DRAIN:
  - payload_tready=1 and hdr_tready=0.
  - Consume beats until tlast; payload content is ignored.
  - On the tlast beat, act by class:
    - OPEN with a free slot: pick the lowest free index with a priority encoder, clear its bit, increment active_count, go to CMD with type OPEN.
    - OPEN with the pool full: increment reject_count, go to RHDR with reply slot 0 (NACK); no command is issued.
    - CLOSE with dest_port in range and allocated: set its bit, decrement active_count, go to CMD with type CLOSE.
    - CLOSE with dest_port out of range or already free: go to IDLE silently.
    - DROP: go to IDLE.
- CMD:
  - conn_setup_req_tvalid is held with stable data until ready.
  - After an OPEN command completes, go to RHDR.
  - After a CLOSE command completes, go to IDLE; CLOSE produces no reply.
- RHDR: drive the reply header and hold it until ready. Fields:
  - src_ip = latched dest_ip; dest_ip = latched src_ip.
  - src_port = allocated slot, or 0 for NACK.
  - dest_port = latched src_port.
  - length = REPLY_LEN.
- RPLD:
  - One beat: tdata = {48'b0, slot16}, tkeep=8'hFF, tlast=1, tuser=0.
  - For NACK, tdata = 64'hFFFF_FFFF_FFFF_FFFF.
  - On handshake, go to IDLE.
- Latency: CMD valid is registered, asserted the cycle after the tlast handshake. RHDR follows the CMD handshake by 1 cycle.
- Only one request is in flight; new headers are back-pressured until IDLE.
- A header together with its single-beat payload can complete in consecutive cycles.
- Bitmap and counter updates happen only in the tlast cycle, so reset mid-operation leaves no partial allocation.
- Slot IDs are compared as 16-bit port values against SLOT_BASE..SLOT_BASE+NUM_SLOTS-1, and are zero-extended into the SLOT_W field.

Decomposition:
- conn_setup_pkg:
  - Setconn type enum: OPEN=1, CLOSE=2.
  - Request-class enum: OPEN/CLOSE/DROP.
  - FSM state enum.
  - UDP header struct: length, dest_port, src_port, dest_ip, src_ip.
  - NACK payload constant.
- Sub-module slot_pool: free bitmap, lowest-free priority encoder, alloc/free ports, full flag and active_count.

Test Plan:
- Open: header src 192.168.1.2:20 -> 192.168.1.128:0, len 16, one beat -> setconn 0x0041 (slot 1, OPEN); reply header 192.168.1.128:1 -> 192.168.1.2:20, len 16, payload 0x...0001.
- Seventeen opens with NUM_SLOTS=16 -> slots 1..16 assigned in order; the 17th gets a NACK reply (src_port 0, payload all-F), no setconn, reject_count=1, active_count=16.
- Close slot 10 (src_port 0, dest_port 10) after the opens -> setconn 0x0282, no reply, active_count drops by 1; the next open reallocates slot 10.
- Close an unallocated slot, dest_port 40 -> no output; counts unchanged. A data header 20 -> 10 with a 3-beat payload -> all beats drained, no output.
- Backpressure: conn_setup_req_tready and tx tready held low 5 cycles -> valids and data stable; rx hdr_tready stays 0 throughout.
- Assert aresetn low during DRAIN of an open -> after release all outputs are 0, active_count is 0, and the next open gets slot 1.
